// File: rtl/address_translation_unit_pkg.sv
// Shared types for the address translation unit: FSM states, TLB entry layout
// and the page permission rule used on both the hit and walk paths.
package address_translation_unit_pkg;

    localparam int ATU_ENTRIES      = 8;
    localparam int ATU_LA_WIDTH     = 32;
    localparam int ATU_PA_WIDTH     = 32;
    localparam int ATU_OFFSET_WIDTH = 12;
    localparam int ATU_PAGE_WIDTH   = ATU_LA_WIDTH - ATU_OFFSET_WIDTH;
    localparam int ATU_FRAME_WIDTH  = ATU_PA_WIDTH - ATU_OFFSET_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WALK,
        ST_RESPOND
    } atu_state_e;

    typedef struct packed {
        logic [ATU_PAGE_WIDTH-1:0]  page;
        logic [ATU_FRAME_WIDTH-1:0] frame;
        logic                       writable;
        logic                       user;
        logic                       valid;
    } tlb_entry_t;

    // Supervisor accesses never fault on the writable bit (no write-protect).
    function automatic logic perm_fault(input logic user_mode, input logic write,
                                        input logic writable, input logic page_user);
        return user_mode && (!page_user || (write && !writable));
    endfunction

endpackage

// File: rtl/address_translation_unit_if.sv
// Request/response, invalidation and page-walker signals of the address translation unit.
// Handshakes: a request is taken when i_vaild=1 while o_busy=0; the walker completes a walk by
// pulsing i_walk_ready for one cycle while o_walk_vaild=1; o_done is a one-cycle result strobe.
interface address_translation_unit_if #(
    parameter int LA_WIDTH     = address_translation_unit_pkg::ATU_LA_WIDTH,
    parameter int PA_WIDTH     = address_translation_unit_pkg::ATU_PA_WIDTH,
    parameter int OFFSET_WIDTH = address_translation_unit_pkg::ATU_OFFSET_WIDTH
);
    import address_translation_unit_pkg::*;

    logic                             i_vaild;
    logic [LA_WIDTH-1:0]              i_linear_address;
    logic                             i_write_enable;
    logic                             i_user_mode;
    logic                             i_paging_enable;
    logic                             i_flush;
    logic                             i_invalidate_vaild;
    logic [LA_WIDTH-1:0]              i_invalidate_address;
    logic                             o_busy;
    logic                             o_done;
    logic [PA_WIDTH-1:0]              o_physical_address;
    logic                             o_page_fault;
    logic                             o_walk_vaild;
    logic [LA_WIDTH-1:0]              o_walk_linear_address;
    logic                             i_walk_ready;
    logic [PA_WIDTH-OFFSET_WIDTH-1:0] i_walk_frame;
    logic                             i_walk_writable;
    logic                             i_walk_user;
    logic                             i_walk_fault;
    atu_state_e                       dbg_state;

    modport master (
        output i_vaild, i_linear_address, i_write_enable, i_user_mode, i_paging_enable,
               i_flush, i_invalidate_vaild, i_invalidate_address,
               i_walk_ready, i_walk_frame, i_walk_writable, i_walk_user, i_walk_fault,
        input  o_busy, o_done, o_physical_address, o_page_fault,
               o_walk_vaild, o_walk_linear_address, dbg_state
    );

    modport slave (
        input  i_vaild, i_linear_address, i_write_enable, i_user_mode, i_paging_enable,
               i_flush, i_invalidate_vaild, i_invalidate_address,
               i_walk_ready, i_walk_frame, i_walk_writable, i_walk_user, i_walk_fault,
        output o_busy, o_done, o_physical_address, o_page_fault,
               o_walk_vaild, o_walk_linear_address, dbg_state
    );

endinterface

// File: rtl/address_translation_unit_tlb.sv
// Fully associative TLB: entry storage, page match, victim selection and round-robin pointer.
module translation_lookaside_buffer
    import address_translation_unit_pkg::*;
#(
    parameter int ENTRIES = ATU_ENTRIES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ATU_PAGE_WIDTH-1:0] lookup_page,
    output logic                      hit,
    output tlb_entry_t                hit_entry,
    input  logic                      fill_en,
    input  tlb_entry_t                fill_entry,
    input  logic                      flush,
    input  logic                      inv_en,
    input  logic [ATU_PAGE_WIDTH-1:0] inv_page
);
    localparam int IDX_WIDTH = $clog2(ENTRIES);

    tlb_entry_t           entries [ENTRIES];
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] victim;
    logic                 have_free;
    tlb_entry_t           fill_data;

    always_comb begin
        hit       = 1'b0;
        hit_entry = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && entries[i].valid && entries[i].page == lookup_page) begin
                hit       = 1'b1;
                hit_entry = entries[i];
            end
        end
    end

    // Scan downward so the lowest-index free slot is the one that sticks.
    always_comb begin
        have_free = 1'b0;
        victim    = rr_ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                have_free = 1'b1;
                victim    = IDX_WIDTH'(i);
            end
        end
    end

    // A fill racing a flush or a matching invalidate lands as an invalid entry.
    always_comb begin
        fill_data       = fill_entry;
        fill_data.valid = !flush && !(inv_en && fill_entry.page == inv_page);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (inv_en && entries[i].page == inv_page) entries[i].valid <= 1'b0;
            end
            if (fill_en) entries[victim] <= fill_data;
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
                rr_ptr <= '0;
            end else if (fill_en && !have_free) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/address_translation_unit.sv
// Linear-to-physical translation: request FSM around a fully associative TLB,
// falling back to an external page walker on a miss.
module address_translation_unit
    import address_translation_unit_pkg::*;
#(
    parameter int ENTRIES      = ATU_ENTRIES,
    parameter int LA_WIDTH     = ATU_LA_WIDTH,
    parameter int PA_WIDTH     = ATU_PA_WIDTH,
    parameter int OFFSET_WIDTH = ATU_OFFSET_WIDTH
) (
    input logic                       clock,
    input logic                       reset,
    address_translation_unit_if.slave bus
);
    atu_state_e          state;
    logic [LA_WIDTH-1:0] req_la;
    logic                req_write;
    logic                req_user;
    logic                tlb_hit;
    tlb_entry_t          tlb_hit_entry;
    logic                fill_en;
    tlb_entry_t          fill_entry;
    logic                hit_fault;
    logic                walk_fault;

    assign hit_fault  = perm_fault(req_user, req_write, tlb_hit_entry.writable, tlb_hit_entry.user);
    assign walk_fault = bus.i_walk_fault
                        || perm_fault(req_user, req_write, bus.i_walk_writable, bus.i_walk_user);
    // Permission-faulting pages are still cached; only a failed walk leaves nothing to cache.
    assign fill_en    = (state == ST_WALK) && bus.i_walk_ready && !bus.i_walk_fault;
    assign bus.dbg_state = state;

    always_comb begin
        fill_entry          = '0;
        fill_entry.page     = req_la[LA_WIDTH-1:OFFSET_WIDTH];
        fill_entry.frame    = bus.i_walk_frame;
        fill_entry.writable = bus.i_walk_writable;
        fill_entry.user     = bus.i_walk_user;
        fill_entry.valid    = 1'b1;
    end

    translation_lookaside_buffer #(.ENTRIES(ENTRIES)) u_tlb (
        .clock      (clock),
        .reset      (reset),
        .lookup_page(req_la[LA_WIDTH-1:OFFSET_WIDTH]),
        .hit        (tlb_hit),
        .hit_entry  (tlb_hit_entry),
        .fill_en    (fill_en),
        .fill_entry (fill_entry),
        .flush      (bus.i_flush),
        .inv_en     (bus.i_invalidate_vaild),
        .inv_page   (bus.i_invalidate_address[LA_WIDTH-1:OFFSET_WIDTH])
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                     <= ST_IDLE;
            req_la                    <= '0;
            req_write                 <= 1'b0;
            req_user                  <= 1'b0;
            bus.o_busy                <= 1'b0;
            bus.o_done                <= 1'b0;
            bus.o_page_fault          <= 1'b0;
            bus.o_physical_address    <= '0;
            bus.o_walk_vaild          <= 1'b0;
            bus.o_walk_linear_address <= '0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_vaild) begin
                        req_la     <= bus.i_linear_address;
                        req_write  <= bus.i_write_enable;
                        req_user   <= bus.i_user_mode;
                        bus.o_busy <= 1'b1;
                        if (bus.i_paging_enable) begin
                            state <= ST_LOOKUP;
                        end else begin
                            state                  <= ST_RESPOND;
                            bus.o_done             <= 1'b1;
                            bus.o_page_fault       <= 1'b0;
                            bus.o_physical_address <= PA_WIDTH'(bus.i_linear_address);
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (tlb_hit) begin
                        state                  <= ST_RESPOND;
                        bus.o_done             <= 1'b1;
                        bus.o_page_fault       <= hit_fault;
                        bus.o_physical_address <= hit_fault ? '0
                                                  : {tlb_hit_entry.frame, req_la[OFFSET_WIDTH-1:0]};
                    end else begin
                        state                     <= ST_WALK;
                        bus.o_walk_vaild          <= 1'b1;
                        bus.o_walk_linear_address <= req_la;
                    end
                end
                ST_WALK: begin
                    if (bus.i_walk_ready) begin
                        state                  <= ST_RESPOND;
                        bus.o_walk_vaild       <= 1'b0;
                        bus.o_done             <= 1'b1;
                        bus.o_page_fault       <= walk_fault;
                        bus.o_physical_address <= walk_fault ? '0
                                                  : {bus.i_walk_frame, req_la[OFFSET_WIDTH-1:0]};
                    end
                end
                ST_RESPOND: begin
                    state      <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_address_translation_unit.sv
// Directed and randomized checks of address_translation_unit against a TLB reference model.
module tb_address_translation_unit;
  import address_translation_unit_pkg::*;

  localparam int N = 8;

  logic clock;
  logic reset;
  int   checks;
  int   passes;
  int   done_pulses;
  int   exp_dones;

  logic [31:0] last_pa;
  bit          last_fault;
  bit          last_walked;
  int          last_lat;

  // Reference model: list of cached translations plus the replacement cursor.
  logic [19:0] m_page  [N];
  logic [19:0] m_frame [N];
  bit          m_w     [N];
  bit          m_u     [N];
  bit          m_valid [N];
  int          m_rr;

  address_translation_unit_if bus ();

  address_translation_unit #(
    .ENTRIES(N), .LA_WIDTH(32), .PA_WIDTH(32), .OFFSET_WIDTH(12)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.o_done === 1'b1) done_pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_perm(bit usr, bit wr, bit w, bit u);
    if (!usr) return 1'b0;
    if (!u) return 1'b1;
    return wr && !w;
  endfunction

  function automatic int model_find(logic [19:0] page);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_page[i] == page) return i;
    return -1;
  endfunction

  function automatic void model_fill(logic [19:0] page, logic [19:0] frame, bit w, bit u);
    int slot;
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    m_page[slot] = page; m_frame[slot] = frame;
    m_w[slot] = w; m_u[slot] = u; m_valid[slot] = 1'b1;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_rr = 0;
  endfunction

  function automatic void model_invalidate(logic [19:0] page);
    for (int i = 0; i < N; i++) if (m_page[i] == page) m_valid[i] = 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_flush();
    @(negedge clock); bus.i_flush = 1'b1;
    @(negedge clock); bus.i_flush = 1'b0;
    model_flush();
  endtask

  task automatic do_invalidate(input logic [31:0] la);
    @(negedge clock); bus.i_invalidate_vaild = 1'b1; bus.i_invalidate_address = la;
    @(negedge clock); bus.i_invalidate_vaild = 1'b0;
    model_invalidate(la[31:12]);
  endtask

  task automatic translate(input string tag, input logic [31:0] la, input bit wr, input bit usr,
                           input bit pg, input logic [19:0] wframe, input bit ww, input bit wu,
                           input bit wf, input int wdelay, input bit flush_at_ready, input bit noise);
    int          idx;
    bit          exp_walk;
    logic [31:0] exp_pa;
    bit          exp_fault;
    int          exp_lat;
    bit          got;
    int          wcnt;
    logic [31:0] wla;
    exp_walk = 1'b0;
    if (!pg) begin
      exp_pa = la; exp_fault = 1'b0; exp_lat = 1;
    end else begin
      idx = model_find(la[31:12]);
      if (idx >= 0) begin
        exp_lat   = 2;
        exp_fault = model_perm(usr, wr, m_w[idx], m_u[idx]);
        exp_pa    = exp_fault ? 32'h0 : {m_frame[idx], la[11:0]};
      end else begin
        exp_walk  = 1'b1;
        exp_lat   = 3 + wdelay;
        exp_fault = wf || model_perm(usr, wr, ww, wu);
        exp_pa    = exp_fault ? 32'h0 : {wframe, la[11:0]};
        if (flush_at_ready) model_flush();
        else if (!wf) model_fill(la[31:12], wframe, ww, wu);
      end
    end
    exp_dones++;

    @(negedge clock);
    bus.i_vaild = 1'b1; bus.i_linear_address = la; bus.i_write_enable = wr;
    bus.i_user_mode = usr; bus.i_paging_enable = pg;
    @(negedge clock);
    if (!noise) bus.i_vaild = 1'b0;
    got = 1'b0; wcnt = 0; wla = '0;
    last_walked = 1'b0; last_lat = 0; last_pa = '0; last_fault = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      bus.i_walk_ready = 1'b0;
      bus.i_flush = 1'b0;
      if (bus.o_done === 1'b1) begin
        got = 1'b1; last_lat = c;
        last_pa = bus.o_physical_address; last_fault = bus.o_page_fault;
        break;
      end
      if (bus.o_walk_vaild === 1'b1) begin
        if (!last_walked) wla = bus.o_walk_linear_address;
        last_walked = 1'b1;
        if (wcnt == wdelay) begin
          bus.i_walk_ready = 1'b1; bus.i_walk_frame = wframe;
          bus.i_walk_writable = ww; bus.i_walk_user = wu; bus.i_walk_fault = wf;
          if (flush_at_ready) bus.i_flush = 1'b1;
        end
        wcnt++;
      end
      if (noise) begin
        bus.i_vaild = 1'b1;
        bus.i_linear_address = $urandom;
        bus.i_paging_enable = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
    end
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " pa"}, last_pa, exp_pa);
    check({tag, " fault"}, 32'(last_fault), 32'(exp_fault));
    check({tag, " latency"}, 32'(last_lat), 32'(exp_lat));
    check({tag, " walked"}, 32'(last_walked), 32'(exp_walk));
    if (exp_walk) check({tag, " walk_la"}, wla, la);
    @(negedge clock);
    check({tag, " busy_after"}, 32'(bus.o_busy), 32'd0);
    check({tag, " done_once"}, 32'(bus.o_done), 32'd0);
    bus.i_vaild = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r_la;
  int          r_sel;
  bit          seen_walk;

  initial begin
    checks = 0; passes = 0; done_pulses = 0; exp_dones = 0;
    for (int i = 0; i < N; i++) begin
      m_page[i] = '0; m_frame[i] = '0; m_w[i] = 1'b0; m_u[i] = 1'b0; m_valid[i] = 1'b0;
    end
    m_rr = 0;
    reset = 1'b0;
    bus.i_vaild = 1'b0; bus.i_linear_address = '0; bus.i_write_enable = 1'b0;
    bus.i_user_mode = 1'b0; bus.i_paging_enable = 1'b0; bus.i_flush = 1'b0;
    bus.i_invalidate_vaild = 1'b0; bus.i_invalidate_address = '0;
    bus.i_walk_ready = 1'b0; bus.i_walk_frame = '0; bus.i_walk_writable = 1'b0;
    bus.i_walk_user = 1'b0; bus.i_walk_fault = 1'b0;

    // Reset values
    #3;
    check("rst busy", 32'(bus.o_busy), 32'd0);
    check("rst done", 32'(bus.o_done), 32'd0);
    check("rst fault", 32'(bus.o_page_fault), 32'd0);
    check("rst walk_vaild", 32'(bus.o_walk_vaild), 32'd0);
    check("rst pa", bus.o_physical_address, 32'd0);
    check("rst walk_la", bus.o_walk_linear_address, 32'd0);
    check("rst state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b1;

    // Paging disabled: identity translation, no walk
    translate("pg_off", 32'h0012_3456, 0, 0, 0, 20'h0, 0, 0, 0, 0, 0, 0);
    check("pg_off pa_const", last_pa, 32'h0012_3456);
    check("pg_off lat_const", 32'(last_lat), 32'd1);

    // Miss then hit on the same page
    translate("miss", 32'h0040_1ABC, 0, 1, 1, 20'h00077, 1, 1, 0, 1, 0, 0);
    check("miss pa_const", last_pa, 32'h0007_7ABC);
    check("miss walked_const", 32'(last_walked), 32'd1);
    translate("hit", 32'h0040_1ABC, 0, 1, 1, 20'h0, 0, 0, 0, 0, 0, 1);
    check("hit walked_const", 32'(last_walked), 32'd0);
    check("hit lat_const", 32'(last_lat), 32'd2);

    // Walk ready outside WALK is ignored
    @(negedge clock); bus.i_walk_ready = 1'b1;
    @(negedge clock); bus.i_walk_ready = 1'b0;
    check("stray_ready busy", 32'(bus.o_busy), 32'd0);
    check("stray_ready done", 32'(bus.o_done), 32'd0);

    // Capacity: nine distinct pages, then probe round-robin replacement
    do_flush();
    for (int i = 0; i < N + 1; i++)
      translate("fill", {20'h00100 + 20'(i), 12'h010}, 0, 0, 1, 20'h20000 + 20'(i), 1, 1, 0, 0, 0, 0);
    translate("rr_keep1", 32'h0010_1020, 0, 0, 1, 20'h0, 0, 0, 0, 0, 0, 0);
    check("rr_keep1 walked_const", 32'(last_walked), 32'd0);
    translate("rr_evict0", 32'h0010_0030, 0, 0, 1, 20'h20000, 1, 1, 0, 0, 0, 0);
    check("rr_evict0 walked_const", 32'(last_walked), 32'd1);
    translate("rr_evict1", 32'h0010_1040, 0, 0, 1, 20'h20001, 1, 1, 0, 0, 0, 0);
    check("rr_evict1 walked_const", 32'(last_walked), 32'd1);

    // Read-only user page: user write faults, supervisor write does not
    do_flush();
    translate("ro_fill", 32'h0050_0123, 0, 0, 1, 20'h00ABC, 0, 1, 0, 2, 0, 0);
    translate("ro_user_wr", 32'h0050_0123, 1, 1, 1, 20'h0, 0, 0, 0, 0, 0, 0);
    check("ro_user_wr fault_const", 32'(last_fault), 32'd1);
    check("ro_user_wr pa_const", last_pa, 32'd0);
    translate("ro_sup_wr", 32'h0050_0123, 1, 0, 1, 20'h0, 0, 0, 0, 0, 0, 0);
    check("ro_sup_wr fault_const", 32'(last_fault), 32'd0);
    check("ro_sup_wr pa_const", last_pa, 32'h00AB_C123);

    // Walk fault: no fill, retry walks again
    translate("wfault", 32'h0060_0004, 0, 0, 1, 20'h00321, 1, 1, 1, 0, 0, 0);
    translate("wfault_retry", 32'h0060_0004, 0, 0, 1, 20'h00321, 1, 1, 0, 0, 0, 0);
    check("wfault_retry walked_const", 32'(last_walked), 32'd1);

    // Flush racing the fill
    translate("flush_race", 32'h0080_0000, 0, 0, 1, 20'h00444, 1, 1, 0, 1, 1, 0);
    check("flush_race pa_const", last_pa, 32'h0044_4000);
    translate("flush_race2", 32'h0080_0000, 0, 0, 1, 20'h00444, 1, 1, 0, 0, 0, 0);
    check("flush_race2 walked_const", 32'(last_walked), 32'd1);

    // Single-page invalidate
    do_invalidate(32'h0080_0FFF);
    translate("inv", 32'h0080_0010, 0, 0, 1, 20'h00445, 1, 1, 0, 0, 0, 0);
    check("inv walked_const", 32'(last_walked), 32'd1);

    // Randomized traffic over a small page pool
    for (int n = 0; n < 60; n++) begin
      r_sel = int'($urandom_range(0, 9));
      r_la = {20'h00A00 + 20'($urandom_range(0, 11)), 12'($urandom)};
      if (r_sel == 0) do_flush();
      else if (r_sel == 1) do_invalidate(r_la);
      translate("rand", r_la, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) != 0, 20'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a walk
    @(negedge clock);
    bus.i_vaild = 1'b1; bus.i_linear_address = 32'h0090_0000;
    bus.i_paging_enable = 1'b1; bus.i_write_enable = 1'b0; bus.i_user_mode = 1'b0;
    @(negedge clock);
    bus.i_vaild = 1'b0;
    seen_walk = 1'b0;
    for (int c = 0; c < 10 && !seen_walk; c++) begin
      if (bus.o_walk_vaild === 1'b1) seen_walk = 1'b1;
      else @(negedge clock);
    end
    check("rstwalk seen", 32'(seen_walk), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstwalk walk_vaild_async", 32'(bus.o_walk_vaild), 32'd0);
    check("rstwalk busy_async", 32'(bus.o_busy), 32'd0);
    repeat (3) begin
      @(negedge clock);
      check("rstwalk no_done", 32'(bus.o_done), 32'd0);
    end
    reset = 1'b1;
    model_flush();
    translate("post_rst", 32'h0080_0010, 0, 0, 1, 20'h00446, 1, 1, 0, 0, 0, 0);
    check("post_rst walked_const", 32'(last_walked), 32'd1);

    repeat (2) @(negedge clock);
    check("done pulse count", 32'(done_pulses), 32'(exp_dones));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/address_translation_unit.md
ADDRESS_TRANSLATION_UNIT -- requirements
Module: address_translation_unit

Interface
REQ-001 SHALL have parameter ENTRIES, 8, TLB entry count; power of two, >= 2.
REQ-002 SHALL have parameter LA_WIDTH, 32, linear address width.
REQ-003 SHALL have parameter PA_WIDTH, 32, physical address width.
REQ-004 SHALL have parameter OFFSET_WIDTH, 12, page offset width; page number = LA_WIDTH-OFFSET_WIDTH, frame = PA_WIDTH-OFFSET_WIDTH.
REQ-005 SHALL have ports: clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low.
REQ-007 i_vaild  in  1  translation request; accepted only when o_busy=0.
REQ-008 i_linear_address  in  LA_WIDTH  address to translate.
REQ-009 i_write_enable  in  1  request is a write; i_user_mode  in  1  request at CPL 3.
REQ-010 i_paging_enable  in  1  CR0.PG; sampled at acceptance.
REQ-011 i_flush  in  1  invalidate all entries (CR3 write); i_invalidate_vaild  in  1, i_invalidate_address  in  LA_WIDTH  invalidate one page.
REQ-012 o_busy  out  1  high whenever state is not IDLE.
REQ-013 o_done  out  1  one-cycle result strobe; o_physical_address  out  PA_WIDTH; o_page_fault  out  1; both valid only while o_done=1.
REQ-014 o_walk_vaild  out  1, o_walk_linear_address  out  LA_WIDTH  page-walk request to walker.
REQ-015 i_walk_ready  in  1  one-cycle walk completion; i_walk_frame  in  PA_WIDTH-OFFSET_WIDTH; i_walk_writable, i_walk_user, i_walk_fault  in  1 each.

Function
REQ-016 States IDLE, LOOKUP, WALK, RESPOND; IDLE accepts i_vaild, capturing address, write, user and paging-enable.
REQ-017 Paging disabled: IDLE->RESPOND; o_done high the cycle after acceptance edge, PA = linear address zero-extended/truncated to PA_WIDTH, fault 0.
REQ-018 Paging enabled: IDLE->LOOKUP; fully associative compare of page number against all valid entries.
REQ-019 Hit: LOOKUP->RESPOND; o_done high 2 cycles after acceptance edge; PA = {entry frame, captured offset}.
REQ-020 Miss: LOOKUP->WALK; o_walk_vaild held high with captured address until i_walk_ready sampled high, then WALK->RESPOND.
REQ-021 Permission fault (hit or walk result): user access to non-user page, or user write to non-writable page; supervisor writes ignore writable bit (no WP).
REQ-022 Walk fault (i_walk_fault=1) or permission fault: o_page_fault=1, o_physical_address=0, no TLB fill for walk fault.
REQ-023 Successful walk SHALL fill one entry (page, frame, writable, user, valid) at the WALK->RESPOND edge, including permission-faulting pages.
REQ-024 Victim: lowest-index invalid entry; if none, round-robin pointer, incremented modulo ENTRIES only on replacement of a valid entry.
REQ-025 RESPOND->IDLE unconditionally; o_done high exactly one cycle per accepted request.
REQ-026 i_vaild while o_busy=1 SHALL be ignored (no queueing).
REQ-027 i_flush clears all valid bits at the next edge in any state; round-robin pointer reset to 0.
REQ-028 i_invalidate_vaild clears any valid entry whose page matches, at next edge, any state.
REQ-029 Flush or matching invalidate on the same edge as a fill: invalidation wins, entry left invalid; translation result still returned.
REQ-030 i_walk_ready outside WALK SHALL be ignored.

Reset
REQ-031 reset low: state IDLE, all valid bits 0, pointer 0, o_busy/o_done/o_page_fault/o_walk_vaild 0, o_physical_address and o_walk_linear_address 0.
REQ-032 reset during WALK SHALL drop o_walk_vaild immediately (asynchronously) and discard the pending request; no o_done.

Structure
REQ-033 Shared package SHALL hold the state enum and the TLB entry struct typedef (page, frame, writable, user, valid), parametrised by widths via package constants.
REQ-034 One sub-module translation_lookaside_buffer SHALL hold entry storage, match, victim select and pointer; the FSM stays in address_translation_unit.

Verification
REQ-035 Paging off, LA 0x0012_3456 -> o_done 1 cycle later, PA 0x0012_3456, fault 0, o_walk_vaild never high.
REQ-036 Paging on, empty TLB, LA 0x0040_1ABC, walker returns frame 0x00077 writable user -> one walk, PA 0x0007_7ABC; repeat -> hit at 2-cycle latency, no walk.
REQ-037 Fill ENTRIES+1 distinct pages -> entries 0..7 filled in order, 9th replaces entry 0, pointer becomes 1.
REQ-038 User write to cached page with writable=0 -> o_page_fault 1, PA 0; same address supervisor write -> PA returned, fault 0.
REQ-039 i_flush asserted same edge as walk completion for LA 0x0080_0000 -> result returned, subsequent request to same page walks again.
REQ-040 reset asserted while o_walk_vaild=1 -> o_walk_vaild 0 without clock, no o_done, next request after release behaves as empty TLB.
